// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared constants and types for the instruction-fetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
package ifu_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_dff.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_dff
//  Description : Enabled D flip-flop bank with synchronous active-high reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_buf
//  Description : DEPTH-entry synchronous FIFO holding fetched {pc, inst}
//                entries; clear wins over push and pop.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch_buf #(
    parameter int W     = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           push_data,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push;

    always_comb begin
        do_push  = push && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    ifu_dff #(.W(PW))   u_wr_ptr (.clk(clk), .rst(rst), .en(1'b1), .d(wr_ptr_d), .q(wr_ptr_q));
    ifu_dff #(.W(PW))   u_rd_ptr (.clk(clk), .rst(rst), .en(1'b1), .d(rd_ptr_d), .q(rd_ptr_q));
    ifu_dff #(.W(PW+1)) u_count  (.clk(clk), .rst(rst), .en(1'b1), .d(count_d),  .q(count_q));

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        ifu_dff #(.W(W)) u_entry (
            .clk (clk),
            .rst (rst),
            .en  (do_push && (wr_ptr_q == PW'(i))),
            .d   (push_data),
            .q   (mem_q[i])
        );
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == (PW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction-fetch front end: sequential PC generation,
//                credit-limited in-order fetch, redirect with flush.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int            AW       = 64,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
    parameter int            DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AW-1:0]     imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [AW-1:0]     redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam int            EW      = AW + INST_W;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] STEP    = AW'(PC_STEP);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count;
    logic [AW-1:0] redirect_tgt;
    logic [EW-1:0] head_entry;
    logic          empty, full;
    logic          accept, push, pop, drop;

    always_comb begin
        redirect_tgt   = {redirect_pc[AW-1:2], 2'b00};
        imem_req_valid = !rst && !redirect_valid &&
                         (({1'b0, outstanding_q} + {1'b0, count}) < DEPTH_C);
        accept         = imem_req_valid && imem_req_ready;
        drop           = (discard_q != '0);
        push           = imem_rsp_valid && !drop && !redirect_valid;
        out_valid      = !rst && !empty && !redirect_valid;
        pop            = out_valid && out_ready;

        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        discard_d     = discard_q;
        if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path,
            // including fetches already marked for discard.
            pc_d      = redirect_tgt;
            rsp_pc_d  = redirect_tgt;
            discard_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (accept)                 pc_d      = pc_q + STEP;
            if (push)                   rsp_pc_d  = rsp_pc_q + STEP;
            if (imem_rsp_valid && drop) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifu_fetch_buf #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (redirect_valid),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .head_data (head_entry),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign imem_req_addr = pc_q;
    assign out_pc        = head_entry[EW-1:INST_W];
    assign out_inst      = head_entry[INST_W-1:0];

    a_credit:  assert property (@(posedge clk) disable iff (rst)
                   ({1'b0, outstanding_q} + {1'b0, count}) <= DEPTH_C);
    a_discard: assert property (@(posedge clk) disable iff (rst) discard_q <= outstanding_q);
    a_push:    assert property (@(posedge clk) disable iff (rst) push |-> !full);
    a_pop:     assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Self-checking bench for ifu_fetch with an in-order memory
//                model and a queue-level reference of the fetch stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] addr;
        int          gen;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    bit          rand_mode = 1'b0;
    req_t        mem_q[$];
    logic [63:0] bufq[$];
    logic [63:0] req_pc = RPC;
    int          gen    = 0;

    ifu_fetch #(
        .AW       (64),
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Memory: answers in order, at least mem_lat cycles after acceptance.
    always @(posedge clk) begin
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        if (rand_mode) imem_req_ready = 1'($urandom_range(0, 1));
    end

    // Reference: stream of PCs tagged with a redirect generation.
    always @(negedge clk) begin : model
        logic exp_rv, exp_ov;
        req_t e;
        exp_rv = !rst && !redirect_valid && (mem_q.size() + bufq.size() < DEPTH);
        exp_ov = !rst && !redirect_valid && (bufq.size() > 0);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, req_pc);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", out_pc, bufq[0]);
            chk("out_inst", 64'(out_inst), 64'(inst_of(bufq[0])));
        end
        if (rst) begin
            mem_q.delete();
            bufq.delete();
            req_pc = RPC;
            gen++;
        end else begin
            e.gen = -1;
            if (imem_rsp_valid) begin
                if (mem_q.size() > 0) e = mem_q.pop_front();
                else chk("rsp_without_request", 64'd1, 64'd0);
            end
            if (redirect_valid) begin
                bufq.delete();
                req_pc = redirect_pc & ~64'h3;
                gen++;
            end else begin
                if (exp_ov && out_ready) void'(bufq.pop_front());
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back('{addr: imem_req_addr, gen: gen, due: cyc + mem_lat});
                    req_pc = imem_req_addr + 64'd4;
                end
                if (imem_rsp_valid && e.gen == gen) bufq.push_back(e.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic redirect(input logic [63:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] a0, a1;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; imem_req_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        step(2);
        rst = 1'b0;

        // 1: latency 1 streaming, three PCs on consecutive cycles
        wait_out("t1");
        chk("t1_pc0", out_pc, 64'h8000_0000);
        @(negedge clk);
        chk("t1_v1", out_valid, 1'b1);
        chk("t1_pc1", out_pc, 64'h8000_0004);
        @(negedge clk);
        chk("t1_v2", out_valid, 1'b1);
        chk("t1_pc2", out_pc, 64'h8000_0008);

        // 2: consumer stalled from a clean start -> credit-limited fetch
        step(1);
        rst = 1'b1; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        chk("t2_accepts", 64'(n), 64'(DEPTH));
        chk("t2_req_off", imem_req_valid, 1'b0);
        step(1);
        out_ready = 1'b1;
        step(20);

        // 3: latency 3, redirect with two fetches in flight
        rst = 1'b1; mem_lat = 3;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1);
        redirect(64'h8000_1002);
        @(negedge clk);
        chk("t3_req_valid_r1", imem_req_valid, 1'b1);
        chk("t3_req_addr_r1", imem_req_addr, 64'h8000_1000);
        wait_out("t3");
        chk("t3_first_pc", out_pc, 64'h8000_1000);

        // 4: redirect together with a response and a ready consumer
        step(1);
        mem_lat = 2;
        step(8);
        for (int i = 0; i < 40 && !(imem_rsp_valid && out_valid); i++) step(1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        @(negedge clk);
        chk("t4_no_pop", out_valid, 1'b0);
        step(1);
        redirect_valid = 1'b0;
        chk("t4_discard", 64'(dut.discard_q), 64'(mem_q.size()));
        wait_out("t4");
        chk("t4_first_pc", out_pc, 64'h8000_2000);

        // back-to-back redirects: the last target wins
        step(5);
        redirect(64'h8000_3000);
        redirect(64'h8000_4000);
        wait_out("t4b");
        chk("t4b_first_pc", out_pc, 64'h8000_4000);

        // 5: random memory and consumer back-pressure
        step(1);
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        rand_mode = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        step(20);

        // 6: PC wrap, then reset mid-stream
        mem_lat = 1;
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        n = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                if (n == 0) a0 = imem_req_addr;
                else        a1 = imem_req_addr;
                n++;
            end
        end
        chk("t6_addr_top", a0, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_addr_wrap", a1, 64'h0);
        step(3);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req_valid", imem_req_valid, 1'b0);
        chk("t6_rst_out_valid", out_valid, 1'b0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_out_valid", out_valid, 1'b0);
        chk("t6_post_req_valid", imem_req_valid, 1'b1);
        chk("t6_post_req_addr", imem_req_addr, RPC);
        wait_out("t6");
        chk("t6_first_pc", out_pc, RPC);
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
